gemm_arbiter: RTL and testbench

GEMM_ARBITER -- requirements
Module: gemm_arbiter

---
 rtl/gemm_arb_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 36 +++
 rtl/gemm_arbiter.sv | 174 +++++++++++++++++
 tb/tb_gemm_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_arb_pkg.sv
// Shared types and constants for the gemm job arbiter: FSM states, response
// codes and the job configuration record latched at grant time.
package gemm_arb_pkg;

    localparam int DIM_W = 8;
    localparam int OFF_W = 9;
    localparam int CYC_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef logic [1:0] rsp_code_t;

    localparam rsp_code_t RSP_OK       = 2'b00;
    localparam rsp_code_t RSP_START_TO = 2'b01;
    localparam rsp_code_t RSP_RUN_TO   = 2'b10;
    localparam rsp_code_t RSP_BAD_CFG  = 2'b11;

    typedef struct packed {
        logic [DIM_W-1:0] k;
        logic [DIM_W-1:0] m;
        logic [DIM_W-1:0] n;
        logic [OFF_W-1:0] offset;
    } job_cfg_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after
// last_grant_i, wrapping around, so last_grant_i itself has lowest priority.
module rr_arbiter #(
    parameter int  NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               grant_valid_o
);

    int               pos;
    logic [IDX_W-1:0] idx;

    always_comb begin
        // NOTE: every variable driven here gets a default first so no path leaves it unassigned and infers a latch.
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        pos           = 0;
        idx           = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            pos = int'(last_grant_i) + off;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            idx = IDX_W'(pos);
            if (!grant_valid_o && req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_o[idx]  = 1'b1;
                grant_idx_o   = idx;
            end
        end
    end

endmodule

// File: rtl/gemm_arbiter.sv
// Shares one gemm engine among NUM_REQ requesters: round-robin grant, single
// job issue, start/run timeouts and a completion pulse back to the job owner.
module gemm_arbiter
    import gemm_arb_pkg::*;
#(
    parameter int  NUM_REQ  = 2,
    parameter int  START_TO = 16,
    parameter int  RUN_TO   = 65535,
    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [DIM_W*NUM_REQ-1:0] req_k,
    input  logic [DIM_W*NUM_REQ-1:0] req_m,
    input  logic [DIM_W*NUM_REQ-1:0] req_n,
    input  logic [OFF_W*NUM_REQ-1:0] req_offset,
    output logic [NUM_REQ-1:0]       rsp_done,
    output logic [1:0]               rsp_code,
    output logic [CYC_W-1:0]         rsp_cycles,
    output logic                     owner_valid,
    output logic [IDX_W-1:0]         owner_id,
    output logic                     g_in_valid,
    output logic [DIM_W-1:0]         g_k,
    output logic [DIM_W-1:0]         g_m,
    output logic [DIM_W-1:0]         g_n,
    output logic [OFF_W-1:0]         g_offset,
    input  logic                     g_busy,
    input  logic                     g_complete
);

    localparam logic [31:0]      START_LAST = 32'(START_TO - 1);
    localparam logic [31:0]      RUN_LAST   = 32'(RUN_TO - 1);
    localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(NUM_REQ - 1);

    state_e           state_q, state_d;
    job_cfg_t         cfg_q, cfg_d, sel_cfg;
    logic [IDX_W-1:0] owner_q, owner_d, last_q, last_d, grant_idx;
    logic             owner_valid_q, owner_valid_d;
    rsp_code_t        code_q, code_d;
    logic [CYC_W-1:0] cyc_q, cyc_d, cyc_inc;
    logic [31:0]      tmo_q, tmo_d;
    logic [NUM_REQ-1:0] grant;
    logic             grant_valid, xfer, bad_cfg;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i         (req_valid),
        .last_grant_i  (last_q),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    assign xfer      = (state_q == ST_IDLE) && grant_valid;
    assign req_ready = (state_q == ST_IDLE) ? grant : '0;
    assign cyc_inc   = (cyc_q == {CYC_W{1'b1}}) ? cyc_q : cyc_q + 1'b1;

    always_comb begin
        sel_cfg = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_cfg.k      = req_k[i*DIM_W +: DIM_W];
                sel_cfg.m      = req_m[i*DIM_W +: DIM_W];
                sel_cfg.n      = req_n[i*DIM_W +: DIM_W];
                sel_cfg.offset = req_offset[i*OFF_W +: OFF_W];
            end
        end
    end

    assign bad_cfg = (sel_cfg.k == '0) || (sel_cfg.m == '0) || (sel_cfg.n == '0);

    always_comb begin
        state_d       = state_q;
        cfg_d         = cfg_q;
        owner_d       = owner_q;
        last_d        = last_q;
        owner_valid_d = owner_valid_q;
        code_d        = code_q;
        cyc_d         = cyc_q;
        tmo_d         = tmo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    cfg_d         = sel_cfg;
                    owner_d       = grant_idx;
                    last_d        = grant_idx;
                    owner_valid_d = 1'b1;
                    cyc_d         = '0;
                    tmo_d         = '0;
                    state_d       = bad_cfg ? ST_DONE : ST_ISSUE;
                    code_d        = bad_cfg ? RSP_BAD_CFG : RSP_OK;
                end
            end
            // The issue cycle itself is the first counted cycle of the job.
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
                cyc_d   = CYC_W'(1);
                tmo_d   = '0;
            end
            ST_WAIT_BUSY: begin
                cyc_d = cyc_inc;
                if (g_complete) begin
                    state_d = ST_DONE;
                    code_d  = RSP_OK;
                end else if (g_busy) begin
                    state_d = ST_RUN;
                    tmo_d   = '0;
                end else if (tmo_q == START_LAST) begin
                    state_d = ST_DONE;
                    code_d  = RSP_START_TO;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            ST_RUN: begin
                cyc_d = cyc_inc;
                if (g_complete) begin
                    state_d = ST_DONE;
                    code_d  = RSP_OK;
                end else if (tmo_q == RUN_LAST) begin
                    state_d = ST_DONE;
                    code_d  = RSP_RUN_TO;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            ST_DONE: begin
                owner_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so each one samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q       <= ST_IDLE;
            cfg_q         <= '0;
            owner_q       <= '0;
            last_q        <= LAST_RST;
            owner_valid_q <= 1'b0;
            code_q        <= RSP_OK;
            cyc_q         <= '0;
            tmo_q         <= '0;
        end else begin
            state_q       <= state_d;
            cfg_q         <= cfg_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            owner_valid_q <= owner_valid_d;
            code_q        <= code_d;
            cyc_q         <= cyc_d;
            tmo_q         <= tmo_d;
        end
    end

    always_comb begin
        rsp_done = '0;
        if (state_q == ST_DONE) rsp_done[owner_q] = 1'b1;
    end

    assign g_in_valid  = (state_q == ST_ISSUE);
    assign g_k         = cfg_q.k;
    assign g_m         = cfg_q.m;
    assign g_n         = cfg_q.n;
    assign g_offset    = cfg_q.offset;
    assign rsp_code    = code_q;
    assign rsp_cycles  = cyc_q;
    assign owner_valid = owner_valid_q;
    assign owner_id    = owner_q;

endmodule

// File: tb/tb_gemm_arbiter.sv
// Bench for gemm_arbiter: job-level model (accept cycle, planned done cycle,
// code) checked every cycle, directed scenarios pinned by literal results.
module tb_gemm_arbiter;

    localparam int N  = 3;
    localparam int ST = 16;
    localparam int RT = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready, rsp_done;
    logic [8*N-1:0] req_k, req_m, req_n;
    logic [9*N-1:0] req_offset;
    logic [1:0]     rsp_code;
    logic [31:0]    rsp_cycles;
    logic           owner_valid;
    logic [1:0]     owner_id;
    logic           g_in_valid, g_busy, g_complete;
    logic [7:0]     g_k, g_m, g_n;
    logic [8:0]     g_offset;

    gemm_arbiter #(.NUM_REQ(N), .START_TO(ST), .RUN_TO(RT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_k(req_k), .req_m(req_m), .req_n(req_n), .req_offset(req_offset),
        .rsp_done(rsp_done), .rsp_code(rsp_code), .rsp_cycles(rsp_cycles),
        .owner_valid(owner_valid), .owner_id(owner_id),
        .g_in_valid(g_in_valid), .g_k(g_k), .g_m(g_m), .g_n(g_n), .g_offset(g_offset),
        .g_busy(g_busy), .g_complete(g_complete)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Requesters: pending flag, held fields, number of back-to-back re-requests.
    bit         pend[N];
    logic [7:0] fk[N], fm[N], fn[N];
    logic [8:0] fo[N];
    int         refill[N];
    bit         rand_req = 1'b0;
    bit         noise_en = 1'b1;
    bit         rst_req  = 1'b1;

    // Job-level model: one active job with its accept cycle and planned outcome.
    int         last = N - 1;
    bit         job_on = 1'b0;
    bit         chk_reset = 1'b0;
    int         j_id, j_acc, j_done, j_b, j_c, j_cycles;
    bit         j_good;
    logic [1:0] j_code;
    logic [7:0] jk, jm, jn;
    logic [8:0] jo;
    int         jobs_done = 0;
    bit         use_dir = 1'b0;
    int         dir_b, dir_c;

    // What the DUT was seen doing, used for the literal pins.
    int         obs_id = -1, obs_done_cyc = 0, obs_acc_cyc = 0, obs_issues = 0;
    logic [1:0] obs_code = '0;
    logic [31:0] obs_cycles = '0;
    int         obs_hist[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    function automatic int pick();
        for (int s = 1; s <= N; s++) begin
            if (pend[(last + s) % N]) return (last + s) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] rnd_dim();
        return ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    endfunction

    // Outcome from the timing rules: first event in the start window decides,
    // complete wins ties; a run lasts at most RT cycles after busy was seen.
    task automatic plan();
        int t;
        t = j_acc + 1;
        if (!j_good) begin
            j_done = j_acc + 1; j_code = 2'b11; j_cycles = 0;
            return;
        end
        if (j_c > 0 && j_c <= ST && (j_b == 0 || j_c <= j_b)) begin
            j_done = t + j_c + 1; j_code = 2'b00;
        end else if (j_b > 0 && j_b <= ST) begin
            if (j_c > j_b && j_c <= j_b + RT) begin
                j_done = t + j_c + 1; j_code = 2'b00;
            end else begin
                j_done = t + j_b + RT + 1; j_code = 2'b10;
            end
        end else begin
            j_done = t + ST + 1; j_code = 2'b01;
        end
        j_cycles = j_done - t;
    endtask

    task automatic rand_scenario();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) begin
            j_b = int'($urandom_range(1, 5)); j_c = j_b + int'($urandom_range(0, 8));
        end else if (r == 6) begin
            j_b = int'($urandom_range(1, 4)); j_c = 0;
        end else if (r == 7) begin
            j_b = 0; j_c = 0;
        end else if (r == 8) begin
            j_b = 0; j_c = int'($urandom_range(1, 20));
        end else begin
            j_b = int'($urandom_range(1, 20)); j_c = int'($urandom_range(1, 20));
        end
    endtask

    task automatic drive();
        int t;
        rst = rst_req;
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = pend[i];
            req_k[8*i +: 8]       = fk[i];
            req_m[8*i +: 8]       = fm[i];
            req_n[8*i +: 8]       = fn[i];
            req_offset[9*i +: 9]  = fo[i];
        end
        g_busy     = noise_en && ($urandom_range(0, 3) == 0);
        g_complete = noise_en && ($urandom_range(0, 3) == 0);
        t = j_acc + 1;
        if (job_on && j_good && cyc > t && cyc < j_done) begin
            g_busy     = (j_b > 0) && (cyc >= t + j_b);
            g_complete = (j_c > 0) && (cyc == t + j_c);
        end
    endtask

    task automatic compare();
        int         p;
        logic [N-1:0] exp_ready, exp_done;
        if (rst) return;
        exp_ready = '0;
        exp_done  = '0;
        p = pick();
        if (!job_on && p >= 0) exp_ready[p] = 1'b1;
        if (job_on && cyc == j_done) exp_done[j_id] = 1'b1;
        if (chk_reset) begin
            check("rst_g_k", g_k, 8'd0);
            check("rst_g_m", g_m, 8'd0);
            check("rst_g_n", g_n, 8'd0);
            check("rst_g_offset", g_offset, 9'd0);
            check("rst_rsp_code", rsp_code, 2'b00);
            check("rst_rsp_cycles", rsp_cycles, 32'd0);
            check("rst_owner_id", owner_id, 2'd0);
            check("rst_req_ready", req_ready, 3'b000);
            chk_reset = 1'b0;
        end
        check("req_ready", req_ready, exp_ready);
        check("g_in_valid", g_in_valid, job_on && j_good && cyc == j_acc + 1);
        check("rsp_done", rsp_done, exp_done);
        check("owner_valid", owner_valid, job_on);
        if (job_on) begin
            check("owner_id", owner_id, j_id);
            check("g_k", g_k, jk);
            check("g_m", g_m, jm);
            check("g_n", g_n, jn);
            check("g_offset", g_offset, jo);
            if (cyc == j_done) begin
                check("rsp_code", rsp_code, j_code);
                check("rsp_cycles", rsp_cycles, j_cycles);
            end
        end
        if (g_in_valid) obs_issues++;
        if (|(req_ready & req_valid)) obs_acc_cyc = cyc;
        if (|rsp_done) begin
            for (int i = 0; i < N; i++) if (rsp_done[i]) obs_id = i;
            obs_code     = rsp_code;
            obs_cycles   = rsp_cycles;
            obs_done_cyc = cyc;
            obs_hist.push_back(obs_id);
        end
    endtask

    task automatic update();
        int p;
        p = -1;
        if (rst) begin
            job_on = 1'b0; last = N - 1; chk_reset = 1'b1;
            return;
        end
        if (job_on) begin
            if (cyc == j_done) begin
                job_on = 1'b0; jobs_done++;
            end
        end else begin
            p = pick();
            if (p >= 0) begin
                j_id = p; j_acc = cyc; last = p;
                jk = fk[p]; jm = fm[p]; jn = fn[p]; jo = fo[p];
                j_good = (jk != 0) && (jm != 0) && (jn != 0);
                if (use_dir) begin
                    j_b = dir_b; j_c = dir_c;
                end else begin
                    rand_scenario();
                end
                plan();
                job_on = 1'b1;
                if (refill[p] > 0) begin
                    refill[p]--;
                    fk[p] = 8'($urandom_range(1, 255)); fm[p] = 8'($urandom_range(1, 255));
                    fn[p] = 8'($urandom_range(1, 255)); fo[p] = 9'($urandom_range(0, 511));
                end else begin
                    pend[p] = 1'b0;
                end
            end
        end
        if (rand_req) begin
            for (int i = 0; i < N; i++) begin
                if (i == p) continue;
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    fk[i] = rnd_dim(); fm[i] = rnd_dim(); fn[i] = rnd_dim();
                    fo[i] = 9'($urandom_range(0, 511));
                end else if (pend[i] && $urandom_range(0, 40) == 0) begin
                    pend[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        compare();
        update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_jobs(input int target);
        int budget;
        budget = 400;
        while (jobs_done < target && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) begin
            n_tests++; n_fail++;
            $display("FAIL job_budget: got %0d jobs done, expected %0d at cycle %0d", jobs_done, target, cyc);
        end
    endtask

    task automatic do_job(input int i, input logic [7:0] k, input logic [7:0] m,
                          input logic [7:0] n, input logic [8:0] off, input int b, input int c);
        fk[i] = k; fm[i] = m; fn[i] = n; fo[i] = off;
        pend[i] = 1'b1;
        use_dir = 1'b1; dir_b = b; dir_c = c;
        run_jobs(jobs_done + 1);
    endtask

    initial begin
        int issues0, h0, budget;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; refill[i] = 0;
            fk[i] = '0; fm[i] = '0; fn[i] = '0; fo[i] = '0;
        end
        drive();
        @(posedge clk);
        #1;
        repeat (2) step();
        rst_req = 1'b0;
        step();

        // Single job: busy at +2, complete at +10.
        issues0 = obs_issues;
        do_job(0, 8'd4, 8'd4, 8'd4, 9'h1A5, 2, 10);
        check("single_id", obs_id, 0);
        check("single_code", obs_code, 2'b00);
        check("single_cycles", obs_cycles, 32'd11);
        check("single_issues", obs_issues - issues0, 1);

        // Bad config on requester 1: no gemm start, done right after accept.
        issues0 = obs_issues;
        do_job(1, 8'd3, 8'd7, 8'd0, 9'd5, 1, 2);
        check("badcfg_id", obs_id, 1);
        check("badcfg_code", obs_code, 2'b11);
        check("badcfg_cycles", obs_cycles, 32'd0);
        check("badcfg_latency", obs_done_cyc - obs_acc_cyc, 1);
        check("badcfg_issues", obs_issues - issues0, 0);

        // Contention: req0 and req1 each hold three jobs back to back.
        h0 = obs_hist.size();
        use_dir = 1'b1; dir_b = 1; dir_c = 3;
        for (int i = 0; i < 2; i++) begin
            fk[i] = 8'd9; fm[i] = 8'd8; fn[i] = 8'd7; fo[i] = 9'(i);
            pend[i] = 1'b1; refill[i] = 2;
        end
        run_jobs(jobs_done + 6);
        for (int j = 0; j < 6; j++) check("contention_order", obs_hist[h0 + j], j % 2);

        // Start timeout, then run timeout.
        do_job(0, 8'd1, 8'd1, 8'd1, 9'd0, 0, 0);
        check("start_to_code", obs_code, 2'b01);
        check("start_to_cycles", obs_cycles, 32'd17);
        do_job(1, 8'd2, 8'd2, 8'd2, 9'd3, 1, 0);
        check("run_to_code", obs_code, 2'b10);
        check("run_to_cycles", obs_cycles, 32'd34);

        // Busy and complete together in the first wait cycle, then a normal job.
        do_job(0, 8'd5, 8'd6, 8'd7, 9'd8, 1, 1);
        check("race_code", obs_code, 2'b00);
        check("race_cycles", obs_cycles, 32'd2);
        do_job(1, 8'd5, 8'd6, 8'd7, 9'd9, 2, 5);
        check("after_race_id", obs_id, 1);
        check("after_race_cycles", obs_cycles, 32'd6);

        // Reset in the middle of a run: job abandoned, req0 wins first afterwards.
        fk[0] = 8'd5; fm[0] = 8'd5; fn[0] = 8'd5; fo[0] = 9'd1;
        pend[0] = 1'b1; dir_b = 1; dir_c = 0;
        budget = 100;
        while (!(job_on && cyc >= j_acc + 6) && budget > 0) begin
            step();
            budget--;
        end
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            fk[i] = 8'd3; fm[i] = 8'd3; fn[i] = 8'd3; fo[i] = 9'(i + 2);
            pend[i] = 1'b1;
        end
        dir_b = 2; dir_c = 4;
        run_jobs(jobs_done + 1);
        check("rst_first_grant", obs_id, 0);

        // Random traffic against the model, then drain.
        use_dir  = 1'b0;
        rand_req = 1'b1;
        repeat (3000) step();
        rand_req = 1'b0;
        repeat (200) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
